// File: rtl/charger_pkg.sv
// Shared encodings and widths for the charger session logic.
package charger_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INPUT    = 2'd1,
        CHARGING = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CONFIRM = 4'd10;
    localparam logic [3:0] KEY_CANCEL  = 4'd11;

    localparam int MONEY_W = 5;
    localparam int TIME_W  = 6;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/charge_session_controller_if.sv
// Keypad-side and amount-manager-side signals of the session controller.
interface charge_session_controller_if;
    import charger_pkg::*;

    logic                key_valid;
    logic [3:0]          key_code;
    logic [MONEY_W-1:0]  am_all_money;
    logic [TIME_W-1:0]   am_remaining_time;
    logic                am_key_valid;
    logic [3:0]          am_key_value;
    logic                am_clear;
    logic                am_start;
    logic [1:0]          state;
    logic                display_en;
    logic                done_led;

    modport slave (
        input  key_valid, key_code, am_all_money, am_remaining_time,
        output am_key_valid, am_key_value, am_clear, am_start,
               state, display_en, done_led
    );

    modport master (
        output key_valid, key_code, am_all_money, am_remaining_time,
        input  am_key_valid, am_key_value, am_clear, am_start,
               state, display_en, done_led
    );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second tick generator; tick is high for one cycle every TICK_DIV
// cycles, counted from the last restart.
module sec_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (restart || div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/charge_session_controller.sv
// Session sequencer: IDLE -> INPUT -> CHARGING -> DONE, with key forwarding,
// amount-manager clear/start control and second-based timeouts.
module charge_session_controller
    import charger_pkg::*;
#(
    parameter int TICK_DIV        = 50000000,
    parameter int INPUT_TIMEOUT_S = 10,
    parameter int DONE_HOLD_S     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    charge_session_controller_if.slave bus
);

    localparam int SEC_MAX = (INPUT_TIMEOUT_S > DONE_HOLD_S) ? INPUT_TIMEOUT_S : DONE_HOLD_S;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    state_t            state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [1:0]        chg_cnt_q, chg_cnt_d;
    logic              am_key_valid_q, am_key_valid_d;
    logic [3:0]        am_key_value_q, am_key_value_d;
    logic              am_clear_q, am_clear_d;
    logic              am_start_q, am_start_d;
    logic              display_en_q, display_en_d;
    logic              done_led_q, done_led_d;

    logic tick;
    logic restart;
    logic key_accept;
    logic key_digit;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign key_digit = bus.key_valid && is_digit(bus.key_code);

    always_comb begin
        state_d        = state_q;
        key_accept     = 1'b0;
        am_key_valid_d = 1'b0;
        am_key_value_d = 4'd0;

        case (state_q)
            IDLE: begin
                if (key_digit) begin
                    state_d        = INPUT;
                    am_key_valid_d = 1'b1;
                    am_key_value_d = bus.key_code;
                end
            end
            INPUT: begin
                // An accepted key takes priority over a timeout in the same cycle.
                if (key_digit) begin
                    key_accept     = 1'b1;
                    am_key_valid_d = 1'b1;
                    am_key_value_d = bus.key_code;
                end else if (bus.key_valid && bus.key_code == KEY_CANCEL) begin
                    state_d = IDLE;
                end else if (bus.key_valid && bus.key_code == KEY_CONFIRM &&
                             bus.am_all_money != '0) begin
                    state_d = CHARGING;
                end else if (tick && sec_q == SEC_W'(INPUT_TIMEOUT_S - 1)) begin
                    state_d = IDLE;
                end
            end
            CHARGING: begin
                // Remaining time is only trusted once the amount manager has loaded it.
                if (chg_cnt_q == 2'd2 && bus.am_remaining_time == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (tick && sec_q == SEC_W'(DONE_HOLD_S - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        restart = (state_d != state_q) || key_accept;

        sec_d = sec_q;
        if (restart) begin
            sec_d = '0;
        end else if (tick && sec_q != '1) begin
            sec_d = sec_q + 1'b1;
        end

        chg_cnt_d = chg_cnt_q;
        if (state_d != state_q) begin
            chg_cnt_d = 2'd0;
        end else if (chg_cnt_q != 2'd2) begin
            chg_cnt_d = chg_cnt_q + 2'd1;
        end

        am_clear_d   = (state_d == IDLE) && (state_q != IDLE);
        am_start_d   = (state_d == CHARGING);
        display_en_d = (state_d != IDLE);
        done_led_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sec_q          <= '0;
            chg_cnt_q      <= 2'd0;
            am_key_valid_q <= 1'b0;
            am_key_value_q <= 4'd0;
            am_clear_q     <= 1'b0;
            am_start_q     <= 1'b0;
            display_en_q   <= 1'b0;
            done_led_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sec_q          <= sec_d;
            chg_cnt_q      <= chg_cnt_d;
            am_key_valid_q <= am_key_valid_d;
            am_key_value_q <= am_key_value_d;
            am_clear_q     <= am_clear_d;
            am_start_q     <= am_start_d;
            display_en_q   <= display_en_d;
            done_led_q     <= done_led_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.am_key_valid = am_key_valid_q;
    assign bus.am_key_value = am_key_value_q;
    assign bus.am_clear     = am_clear_q;
    assign bus.am_start     = am_start_q;
    assign bus.display_en   = display_en_q;
    assign bus.done_led     = done_led_q;

endmodule

// File: tb/tb_charge_session_controller.sv
// Scoreboard bench: stimulus predicts timestamped output events, a negedge
// monitor pops and compares them as the controller produces them.
module tb_charge_session_controller;

    localparam int TICK = 10;
    localparam int TOUT = 10 * TICK;
    localparam int HOLD = 5 * TICK;
    localparam int K_STATE = 0, K_KEY = 1, K_CLEAR = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    int   prev_state = 0;
    int   exp_state = 0;
    int   load_r = 0;
    bit   am_loaded = 1'b0;
    logic am_start_seen;
    ev_t  exp_q[$];

    charge_session_controller_if bus ();

    charge_session_controller #(
        .TICK_DIV        (TICK),
        .INPUT_TIMEOUT_S (10),
        .DONE_HOLD_S     (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Amount manager stand-in: loads the charge time one cycle after start is seen.
    always @(posedge clk) begin
        am_start_seen = bus.am_start;
        #1;
        if (!am_start_seen) begin
            bus.am_remaining_time = '0;
            am_loaded = 1'b0;
        end else if (!am_loaded) begin
            bus.am_remaining_time = 6'(load_r);
            am_loaded = 1'b1;
        end else if (bus.am_remaining_time != '0) begin
            bus.am_remaining_time = bus.am_remaining_time - 6'd1;
        end
    end

    function automatic string kname(input int kind);
        case (kind)
            K_STATE: return "state";
            K_KEY:   return "key";
            default: return "clear";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got %0d at cycle %0d, required no event",
                     kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got %s=%0d @%0d, required %s=%0d @%0d",
                         kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end else begin
                $display("cycle %0d: %s=%0d matched", cyc, kname(kind), val);
            end
            if (e.kind == K_STATE) exp_state = e.val;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(bus.state) != prev_state) begin
                prev_state = int'(bus.state);
                check_ev(K_STATE, prev_state);
            end
            if (bus.am_key_valid) check_ev(K_KEY, int'(bus.am_key_value));
            else chk("key_value_idle", int'(bus.am_key_value), 0);
            if (bus.am_clear) check_ev(K_CLEAR, 0);
            chk("level_outputs",
                {int'(bus.state), int'(bus.display_en), int'(bus.done_led), int'(bus.am_start)},
                {exp_state, int'(exp_state != 0), int'(exp_state == 3), int'(exp_state == 2)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic press(input int code, output int c);
        c = cyc;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(code);
        step();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
    endtask

    // CONFIRM with money loaded: charging, done after r+2 more cycles, hold, idle.
    task automatic charge(input int money, input int r);
        int c;
        bus.am_all_money = 5'(money);
        load_r = r;
        press(10, c);
        expect_ev(K_STATE, 2, c + 1);
        expect_ev(K_STATE, 3, c + 3 + r);
        expect_ev(K_STATE, 0, c + 3 + r + HOLD);
        expect_ev(K_CLEAR, 0, c + 3 + r + HOLD);
    endtask

    initial begin
        int c, last, d, m, r, choice;
        bus.key_valid = 1'b0;
        bus.key_code = 4'd0;
        bus.am_all_money = '0;
        bus.am_remaining_time = '0;
        mon_en = 1'b1;
        step_n(3);
        rst_n = 1'b1;
        step_n(100);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_outputs",
            {int'(bus.am_key_valid), int'(bus.am_clear), int'(bus.am_start),
             int'(bus.display_en), int'(bus.done_led)}, 0);

        // Key 8, key 9, confirm with 20, charge 40 seconds of model time.
        press(8, c);
        expect_ev(K_STATE, 1, c + 1);
        expect_ev(K_KEY, 8, c + 1);
        bus.am_all_money = 5'd8;
        step_n(2);
        press(9, c);
        expect_ev(K_KEY, 9, c + 1);
        bus.am_all_money = 5'd20;
        step();
        charge(20, 40);
        wait_until(c + 60 + 40 + HOLD);
        bus.am_all_money = '0;

        // Entry timeout, restarted by a key at 95 and by one landing on the expiry cycle.
        press(1, c);
        expect_ev(K_STATE, 1, c + 1);
        expect_ev(K_KEY, 1, c + 1);
        wait_until(c + 95);
        press(2, c);
        expect_ev(K_KEY, 2, c + 1);
        wait_until(c + TOUT);
        press(3, c);
        expect_ev(K_KEY, 3, c + 1);
        expect_ev(K_STATE, 0, c + 1 + TOUT);
        expect_ev(K_CLEAR, 0, c + 1 + TOUT);
        wait_until(c + TOUT + 5);

        // Zero-money confirm is ignored, then cancel.
        press(4, c);
        expect_ev(K_STATE, 1, c + 1);
        expect_ev(K_KEY, 4, c + 1);
        press(10, c);
        step_n(2);
        press(11, c);
        expect_ev(K_STATE, 0, c + 1);
        expect_ev(K_CLEAR, 0, c + 1);
        step_n(3);

        // Keys during charging are ignored.
        press(5, c);
        expect_ev(K_STATE, 1, c + 1);
        expect_ev(K_KEY, 5, c + 1);
        step();
        charge(5, 30);
        step_n(4);
        press(11, d);
        press(5, d);
        wait_until(c + 40 + HOLD);
        bus.am_all_money = '0;

        // Asynchronous reset in the middle of charging.
        press(7, c);
        expect_ev(K_STATE, 1, c + 1);
        expect_ev(K_KEY, 7, c + 1);
        bus.am_all_money = 5'd7;
        load_r = 30;
        press(10, c);
        expect_ev(K_STATE, 2, c + 1);
        wait_until(c + 10);
        expect_ev(K_STATE, 0, cyc);
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", int'(bus.state), 0);
        chk("async_reset_start", int'(bus.am_start), 0);
        chk("async_reset_display", int'(bus.display_en), 0);
        step_n(2);
        rst_n = 1'b1;
        bus.am_all_money = '0;
        step_n(20);

        // Randomized sessions.
        for (int s = 0; s < 10; s++) begin
            repeat ($urandom_range(0, 2)) begin
                press(int'($urandom_range(10, 15)), c);
                step_n(int'($urandom_range(0, 2)));
            end
            d = int'($urandom_range(0, 9));
            press(d, c);
            expect_ev(K_STATE, 1, c + 1);
            expect_ev(K_KEY, d, c + 1);
            last = c;
            repeat ($urandom_range(0, 3)) begin
                step_n(int'($urandom_range(0, 4)));
                d = int'($urandom_range(0, 9));
                press(d, c);
                expect_ev(K_KEY, d, c + 1);
                last = c;
            end
            choice = int'($urandom_range(0, 2));
            if (choice == 0) begin
                expect_ev(K_STATE, 0, last + 1 + TOUT);
                expect_ev(K_CLEAR, 0, last + 1 + TOUT);
                wait_until(last + TOUT + 4);
            end else if (choice == 1) begin
                step_n(int'($urandom_range(0, 3)));
                press(11, c);
                expect_ev(K_STATE, 0, c + 1);
                expect_ev(K_CLEAR, 0, c + 1);
                step_n(3);
            end else begin
                m = int'($urandom_range(1, 31));
                r = int'($urandom_range(3, 40));
                if ($urandom_range(0, 1) == 1) begin
                    bus.am_all_money = '0;
                    press(10, c);
                end
                c = cyc;
                charge(m, r);
                repeat ($urandom_range(0, 3)) press(int'($urandom_range(0, 15)), d);
                wait_until(c + 6 + r + HOLD);
                bus.am_all_money = '0;
            end
        end

        step_n(5);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got none, required %s=%0d @%0d",
                     kname(e.kind), e.val, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/charge_session_controller.md
Name: charge_session_controller

Overview:
- Top-level session sequencer for the coin-operated charger.
- Sits between the keypad decoder and the amount manager, and owns the session state: idle, coin/amount entry, charging, done.
- Forwards digit keys to the amount manager, issues its clear and start controls, and applies entry and done timeouts using an internal one-second tick.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick (50 MHz); benches use 10.
- INPUT_TIMEOUT_S, 10, seconds without a key in INPUT before the session is abandoned.
- DONE_HOLD_S, 5, seconds the DONE indication is held before returning to IDLE.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle pulse; key_code valid in that cycle.
- key_code  in  4  0-9 digit; 10 CONFIRM; 11 CANCEL; 12-15 ignored.
- am_all_money  in  5  accumulated amount from the amount manager.
- am_remaining_time  in  6  remaining charge time from the amount manager.
- am_key_valid  out  1  one-cycle strobe forwarding a digit.
- am_key_value  out  4  forwarded digit; 0 when am_key_valid is low.
- am_clear  out  1  one-cycle synchronous clear to the amount manager.
- am_start  out  1  level; high throughout CHARGING.
- state  out  2  IDLE=0, INPUT=1, CHARGING=2, DONE=3.
- display_en  out  1  high in INPUT, CHARGING and DONE.
- done_led  out  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE;
  - all outputs 0;
  - tick divider 0 and second counter 0.
- All outputs are registered.
- Second counter: increments on each tick. It restarts, together with the divider, on every state change and on every accepted key in INPUT. Timeouts are therefore measured from the last event, in whole seconds.
- IDLE:
  - Digit key -> INPUT next cycle, and the digit is forwarded.
  - CONFIRM, CANCEL and codes 12-15 are ignored.
- INPUT:
  - Digit -> am_key_valid=1 and am_key_value=digit exactly one cycle after the key_valid cycle.
  - CONFIRM with am_all_money!=0 -> CHARGING.
  - CONFIRM with am_all_money==0 is ignored.
  - CANCEL -> IDLE.
  - Second counter reaching INPUT_TIMEOUT_S -> IDLE.
- CHARGING:
  - am_start=1 from the first CHARGING cycle.
  - Keys are ignored, including CANCEL (the charge is paid).
  - Exit to DONE when am_remaining_time==0, evaluated only after 2 cycles in CHARGING. This guard covers the amount manager's load latency.
- DONE:
  - am_start=0, done_led=1.
  - Keys are ignored.
  - After DONE_HOLD_S seconds -> IDLE.
- Every entry into IDLE from another state emits am_clear=1 for exactly one cycle (the first IDLE cycle). Reset itself does not pulse am_clear.
- Simultaneous events in INPUT:
  - A key arriving in the same cycle the timeout expires wins: it is processed and the counter restarts.
  - CANCEL is never forwarded as a digit.
- key_valid held high for several cycles is treated as one key per cycle. Debouncing is upstream.
- am_key_value returns to 0 in the cycle after the strobe.
- Reset mid-session: immediate async return to IDLE, no am_clear pulse. The amount manager shares rst_n.
- Counter widths are sized from the parameters with $clog2. The divider wraps at TICK_DIV-1.

Decomposition:
- Shared package charger_pkg holds:
  - state encoding constants IDLE/INPUT/CHARGING/DONE;
  - key code constants KEY_CONFIRM=10 and KEY_CANCEL=11;
  - width constants MONEY_W=5 and TIME_W=6.
- One sub-module, sec_tick_gen. Ports: clk, rst_n, restart, tick. Parameter: TICK_DIV. It produces a one-cycle tick every TICK_DIV cycles after restart.

Test Plan:
- Reset release, no keys for 100 cycles -> state=0, all outputs 0, no am_clear.
- IDLE, key 8 then key 9 (money model returns 8 then 20), CONFIRM:
  - two am_key_valid strobes with values 8 and 9, each one cycle after its key;
  - then state=2 and am_start=1;
  - model counts remaining_time 40 to 0 -> state=3, done_led=1, am_start=0;
  - after 5 ticks (50 cycles with TICK_DIV=10) -> state=0 with a single am_clear pulse.
- IDLE, key 1, no further keys -> INPUT; at 10 ticks (100 cycles) -> IDLE with am_clear pulse. A key at cycle 95 restarts the timeout to 100 cycles from that key.
- INPUT with money 0, CONFIRM -> stays INPUT, am_start stays 0. Then CANCEL -> IDLE, am_clear pulse, no am_key_valid for CANCEL.
- CHARGING with remaining_time=30, CANCEL and digit 5 -> ignored: am_key_valid stays 0, state stays 2.
- rst_n pulsed low mid-CHARGING -> outputs 0 asynchronously, state=0, no am_clear pulse after release.
